// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    CLS_RALU  = 4'd0,
    CLS_IALU  = 4'd1,
    CLS_LOAD  = 4'd2,
    CLS_STORE = 4'd3,
    CLS_BR    = 4'd4,
    CLS_J     = 4'd5,
    CLS_JAL   = 4'd6,
    CLS_JR    = 4'd7,
    CLS_JALR  = 4'd8,
    CLS_ILL   = 4'd9
  } cls_e;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] FUNCT_JR   = 6'd8;
  localparam logic [5:0] FUNCT_JALR = 6'd9;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] REG_DEST_RT = 2'd0;
  localparam logic [1:0] REG_DEST_RD = 2'd1;
  localparam logic [1:0] REG_DEST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_LINK = 2'd2;

endpackage

// File: rtl/mips_inst_classify.sv
// Combinational instruction classifier: opcode/funct to instruction class.
module mips_inst_classify
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output cls_e        cls
);

  logic [5:0] opcode;
  logic [5:0] funct;
  // Only opcode and funct select the class; the remaining fields are datapath-only.
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  // Priority decode of opcode groups; anything unmatched is illegal.
  always_comb begin
    cls = CLS_ILL;
    if (opcode == OP_SPECIAL) begin
      if (funct == FUNCT_JR)
        cls = CLS_JR;
      else if (funct == FUNCT_JALR)
        cls = CLS_JALR;
      else
        cls = CLS_RALU;
    end else if (opcode == OP_REGIMM || opcode[5:2] == 4'b0001) begin
      cls = CLS_BR;
    end else if (opcode == OP_J) begin
      cls = CLS_J;
    end else if (opcode == OP_JAL) begin
      cls = CLS_JAL;
    end else if (opcode[5:3] == 3'b001) begin
      cls = CLS_IALU;
    end else if (opcode[5:3] == 3'b100) begin
      cls = CLS_LOAD;
    end else if (opcode[5:3] == 3'b101) begin
      cls = CLS_STORE;
    end
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle MIPS control unit: fetch/decode/execute/memory/writeback sequencing
// with memory wait handshake and stuck-memory timeout.
//
// state  | meaning
// IDLE   | one cycle after reset, all outputs low
// FETCH  | instruction read; IR/PC written on the cycle wait drops
// DECODE | class registered; illegal instructions retire here
// EXEC   | ALU operand select, branches and jumps (jumps/branches retire here)
// MEM    | load/store strobe held across waitrequest
// WB     | register-file write for ALU ops and loads
// HALT   | memory timed out; parked until reset
module mips_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 1024,
  parameter bit EN_LINK      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src,
  output logic        branch,
  output logic        reg_write,
  output logic [1:0]  reg_dest,
  output logic [1:0]  mem_to_reg,
  output logic        instr_done,
  output logic        illegal,
  output logic        timeout_err
);

  localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  // Count value at the start of the last allowed waiting cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state;
  state_e           state_nxt;
  cls_e             cls_q;
  cls_e             instr_cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             in_wait_state;
  logic             timeout_hit;

  mips_inst_classify u_classify (
    .instr (instr),
    .cls   (instr_cls)
  );

  assign in_wait_state = (state == S_FETCH) || (state == S_MEM);
  assign timeout_hit   = (WAIT_TIMEOUT > 0) && in_wait_state && mem_waitrequest &&
                         (wait_cnt == CNT_LAST);
  assign timeout_err   = err_q;

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH: begin
        if (timeout_hit)
          state_nxt = S_HALT;
        else if (!mem_waitrequest)
          state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = (instr_cls == CLS_ILL) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          CLS_RALU, CLS_IALU:  state_nxt = S_WB;
          CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
          default:             state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (timeout_hit)
          state_nxt = S_HALT;
        else if (!mem_waitrequest)
          state_nxt = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
      end
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, class, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cls_q    <= CLS_RALU;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        cls_q <= instr_cls;
      if (state_nxt != state || !mem_waitrequest || !in_wait_state)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + CNT_ONE;
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end

  // Output decode from registered state/class; waitrequest only gates handshake edges.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    alu_src    = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    reg_dest   = REG_DEST_RT;
    mem_to_reg = M2R_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = !mem_waitrequest;
        pc_write = !mem_waitrequest;
      end
      S_DECODE: begin
        illegal    = (instr_cls == CLS_ILL);
        instr_done = (instr_cls == CLS_ILL);
      end
      S_EXEC: begin
        case (cls_q)
          CLS_IALU, CLS_LOAD, CLS_STORE: alu_src = 1'b1;
          CLS_BR: begin
            branch     = 1'b1;
            pc_src     = PC_SRC_BRANCH;
            instr_done = 1'b1;
          end
          CLS_J, CLS_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            instr_done = 1'b1;
          end
          CLS_JR, CLS_JALR: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_REG;
            instr_done = 1'b1;
          end
          default: ;
        endcase
        if (EN_LINK && (cls_q == CLS_JAL || cls_q == CLS_JALR)) begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_LINK;
          reg_dest   = (cls_q == CLS_JAL) ? REG_DEST_RA : REG_DEST_RD;
        end
      end
      S_MEM: begin
        mem_read   = (cls_q == CLS_LOAD);
        mem_write  = (cls_q == CLS_STORE);
        instr_done = (cls_q == CLS_STORE) && !mem_waitrequest;
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        if (cls_q == CLS_LOAD) begin
          mem_to_reg = M2R_MEM;
          reg_dest   = REG_DEST_RT;
        end else if (cls_q == CLS_RALU) begin
          reg_dest = REG_DEST_RD;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm; one task per scenario, per-cycle expected output vectors.
module tb_mips_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        mem_waitrequest;
  logic        mem_read, mem_write, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src, branch, reg_write;
  logic [1:0]  reg_dest, mem_to_reg;
  logic        instr_done, illegal, timeout_err;

  int total = 0;
  int bad   = 0;

  // Field order: mem_read mem_write ir_write pc_write _ pc_src _ alu_src branch reg_write
  //              _ reg_dest _ mem_to_reg _ instr_done illegal
  logic [14:0] outs;
  assign outs = {mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, branch,
                 reg_write, reg_dest, mem_to_reg, instr_done, illegal};

  localparam logic [14:0] V_ZERO   = 15'b0000_00_000_00_00_00;
  localparam logic [14:0] V_FWAIT  = 15'b1000_00_000_00_00_00;
  localparam logic [14:0] V_FGO    = 15'b1011_00_000_00_00_00;
  localparam logic [14:0] V_ILL    = 15'b0000_00_000_00_00_11;
  localparam logic [14:0] V_IMM    = 15'b0000_00_100_00_00_00;
  localparam logic [14:0] V_WBR    = 15'b0000_00_001_01_00_10;
  localparam logic [14:0] V_WBI    = 15'b0000_00_001_00_00_10;
  localparam logic [14:0] V_WBL    = 15'b0000_00_001_00_01_10;
  localparam logic [14:0] V_LDMEM  = 15'b1000_00_000_00_00_00;
  localparam logic [14:0] V_STWAIT = 15'b0100_00_000_00_00_00;
  localparam logic [14:0] V_STDONE = 15'b0100_00_000_00_00_10;
  localparam logic [14:0] V_JAL    = 15'b0001_10_001_10_10_10;
  localparam logic [14:0] V_JR     = 15'b0001_11_000_00_00_10;
  localparam logic [14:0] V_BR     = 15'b0000_01_010_00_00_10;

  mips_ctrl_fsm #(.WAIT_TIMEOUT(4), .EN_LINK(1'b1)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr           (instr),
    .mem_waitrequest (mem_waitrequest),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ir_write        (ir_write),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .alu_src         (alu_src),
    .branch          (branch),
    .reg_write       (reg_write),
    .reg_dest        (reg_dest),
    .mem_to_reg      (mem_to_reg),
    .instr_done      (instr_done),
    .illegal         (illegal),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle, drive waitrequest for it, let outputs settle.
  task automatic cyc(input logic w);
    @(negedge clk);
    mem_waitrequest = w;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    instr = 32'h0;
    mem_waitrequest = 1'b0;
    #3;
    total++;
    if (outs !== V_ZERO || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_asserted outs=%b err=%b want outs=%b err=0", outs, timeout_err, V_ZERO);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (outs !== V_ZERO) begin
      bad++;
      $display("FAIL reset_idle outs=%b want %b", outs, V_ZERO);
    end
  endtask

  // addu with waitrequest high in DECODE/EXEC/WB, which must be ignored.
  task automatic test_addu();
    logic        w  [4];
    logic [14:0] ev [4];
    int          done_cnt;
    w  = '{1'b0, 1'b1, 1'b1, 1'b1};
    ev = '{V_FGO, V_ZERO, V_ZERO, V_WBR};
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(w[i]);
      if (i == 0) instr = 32'h00851021;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL addu cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
      if (instr_done) done_cnt++;
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL addu_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_lw();
    logic        w  [10];
    logic [14:0] ev [10];
    w  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ev = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FGO, V_ZERO, V_IMM,
           V_LDMEM, V_LDMEM, V_LDMEM, V_WBL};
    for (int i = 0; i < 10; i++) begin
      cyc(w[i]);
      if (i == 0) instr = 32'h8C820004;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL lw cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
    end
  endtask

  task automatic test_sw();
    logic [14:0] ev [4];
    ev = '{V_FGO, V_ZERO, V_IMM, V_STDONE};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0);
      if (i == 0) instr = 32'hAC820008;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL sw cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
    end
  endtask

  // jal then jr $31, back to back.
  task automatic test_jumps();
    logic [14:0] ev [6];
    ev = '{V_FGO, V_ZERO, V_JAL, V_FGO, V_ZERO, V_JR};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      if (i == 0) instr = 32'h0C000010;
      if (i == 3) instr = 32'h03E00008;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL jumps cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
    end
  endtask

  // beq followed immediately by ori.
  task automatic test_back_to_back();
    logic [14:0] ev [7];
    int          done_cnt;
    ev = '{V_FGO, V_ZERO, V_BR, V_FGO, V_ZERO, V_IMM, V_WBI};
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0);
      if (i == 0) instr = 32'h10850003;
      if (i == 3) instr = 32'h34820005;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL b2b cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
      if (instr_done) done_cnt++;
    end
    total++;
    if (done_cnt !== 2) begin
      bad++;
      $display("FAIL b2b_done_count got %0d want 2", done_cnt);
    end
  endtask

  // Three waiting cycles pass; four waiting cycles halt.
  task automatic test_timeout();
    logic        w3 [5];
    logic [14:0] e3 [5];
    logic        w4 [7];
    logic [14:0] e4 [7];
    logic        t4 [7];
    w3 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e3 = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FGO, V_ILL};
    for (int i = 0; i < 5; i++) begin
      cyc(w3[i]);
      if (i == 0) instr = 32'hFC000000;
      total++;
      if (outs !== e3[i] || timeout_err !== 1'b0) begin
        bad++;
        $display("FAIL wait3 cyc%0d outs=%b err=%b want outs=%b err=0", i, outs, timeout_err, e3[i]);
      end
    end
    w4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    e4 = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FWAIT, V_ZERO, V_ZERO, V_ZERO};
    t4 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cyc(w4[i]);
      total++;
      if (outs !== e4[i] || timeout_err !== t4[i]) begin
        bad++;
        $display("FAIL wait4 cyc%0d outs=%b err=%b want outs=%b err=%b", i, outs, timeout_err, e4[i], t4[i]);
      end
    end
  endtask

  // Leave HALT via reset, then drop reset in the middle of a store's MEM wait.
  task automatic test_reset_mid();
    logic        w  [4];
    logic [14:0] ev [4];
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (timeout_err !== 1'b0 || outs !== V_ZERO) begin
      bad++;
      $display("FAIL halt_reset err=%b outs=%b want err=0 outs=%b", timeout_err, outs, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    #1;
    w  = '{1'b0, 1'b0, 1'b0, 1'b1};
    ev = '{V_FGO, V_ZERO, V_IMM, V_STWAIT};
    for (int i = 0; i < 4; i++) begin
      cyc(w[i]);
      if (i == 0) instr = 32'hAC820008;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL sw_pre_reset cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
    end
    #1;
    reset = 1'b0;
    #1;
    total++;
    if (mem_write !== 1'b0 || outs !== V_ZERO) begin
      bad++;
      $display("FAIL async_reset mem_write=%b outs=%b want 0 and %b", mem_write, outs, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    #1;
    total++;
    if (outs !== V_ZERO) begin
      bad++;
      $display("FAIL post_reset_idle outs=%b want %b", outs, V_ZERO);
    end
    ev = '{V_FGO, V_ILL, V_FWAIT, V_FWAIT};
    for (int i = 0; i < 3; i++) begin
      cyc(i == 2);
      if (i == 0) instr = 32'hFC000000;
      total++;
      if (outs !== ev[i]) begin
        bad++;
        $display("FAIL ill_after_reset cyc%0d outs=%b want %b", i, outs, ev[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw();
    test_sw();
    test_jumps();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
